mux_arb_width_chan: RTL and testbench

- Parametrised successor to the combinational width/channel multiplexer.
- Selects one of CHANNELS input words of WIDTH bits and registers it behind a valid/ready handshake.
- Two modes: explicit select (MODE=0) or round-robin arbitration among requesting channels (MODE=1).
- Sits between ALU result sources and the shared writeback/result bus, where several producers compete for one consumer.

---
 rtl/mux_arb_width_chan.sv | 76 +++++++
 tb/tb_mux_arb_width_chan.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_width_chan.sv
// mux_arb_width_chan: picks one of CHANNELS words (explicit select or round-robin) and registers it behind valid/ready
module mux_arb_width_chan #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    parameter int SEL_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    output logic                      sel_err,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);
    localparam logic [SEL_W:0]   CH_N = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS-1);
    logic [SEL_W-1:0] ptr, gnt_idx, hi_idx, any_idx;
    logic             gnt_v, hi_v, any_v, load, xfer;
    logic [WIDTH-1:0] gnt_data;

    assign load     = !out_valid || out_ready;
    assign xfer     = load && gnt_v;
    assign sel_err  = (MODE == 0) && ({1'b0, sel} >= CH_N);
    assign in_ready = (xfer && !rst) ? CHANNELS'(1) << gnt_idx : '0;

    // Grant: in select mode only the addressed channel qualifies; in round-robin the lowest
    // requester at or above ptr wins, falling back to the lowest requester overall (wrap).
    always_comb begin
        hi_v     = 1'b0;
        hi_idx   = '0;
        any_v    = 1'b0;
        any_idx  = '0;
        gnt_data = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (in_valid[c] && (MODE != 0 || sel == SEL_W'(c))) begin
                any_v   = 1'b1;
                any_idx = SEL_W'(c);
                if (MODE == 0 || SEL_W'(c) >= ptr) begin
                    hi_v   = 1'b1;
                    hi_idx = SEL_W'(c);
                end
            end
        end
        gnt_v   = any_v;
        gnt_idx = hi_v ? hi_idx : any_idx;
        for (int c = 0; c < CHANNELS; c++) begin
            if (gnt_idx == SEL_W'(c)) gnt_data = in_bus[c*WIDTH +: WIDTH];
        end
    end

    // Output register: reload whenever the slot is free or being drained this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load) begin
            out_valid <= gnt_v;
            if (gnt_v) begin
                out_data <= gnt_data;
                out_chan <= gnt_idx;
            end
        end
    end

    // Round-robin pointer moves just past the winner on each transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= '0;
        else if (MODE != 0 && xfer) ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + SEL_W'(1);
    end
endmodule

// File: tb/tb_mux_arb_width_chan.sv
// tb_mux_arb_width_chan: scoreboard bench for select-mode, round-robin and out-of-range instances
module tb_mux_arb_width_chan;
    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] bus[2];
    logic [3:0]  iv[2], ir[2], sel[2], oc[2], took[2];
    logic [7:0]  od[2];
    logic        ov[2], ordy[2], serr[2];
    logic [23:0] bus2;
    logic [2:0]  iv2, ir2;
    logic [3:0]  sel2, oc2;
    logic [7:0]  od2;
    logic        ov2, or2, serr2;
    logic [11:0] q0[$], q1[$];
    int          mptr = 0;
    int          pass_cnt = 0, tot_cnt = 0;
    bit          rand_on = 0;

    always #5 clk = ~clk;

    mux_arb_width_chan #(.WIDTH(8), .CHANNELS(4), .MODE(0), .SEL_W(4)) d0 (
        .clk(clk), .rst(rst), .in_bus(bus[0]), .in_valid(iv[0]), .in_ready(ir[0]), .sel(sel[0]),
        .sel_err(serr[0]), .out_data(od[0]), .out_chan(oc[0]), .out_valid(ov[0]), .out_ready(ordy[0]));
    mux_arb_width_chan #(.WIDTH(8), .CHANNELS(4), .MODE(1), .SEL_W(4)) d1 (
        .clk(clk), .rst(rst), .in_bus(bus[1]), .in_valid(iv[1]), .in_ready(ir[1]), .sel(sel[1]),
        .sel_err(serr[1]), .out_data(od[1]), .out_chan(oc[1]), .out_valid(ov[1]), .out_ready(ordy[1]));
    mux_arb_width_chan #(.WIDTH(8), .CHANNELS(3), .MODE(0), .SEL_W(4)) d2 (
        .clk(clk), .rst(rst), .in_bus(bus2), .in_valid(iv2), .in_ready(ir2), .sel(sel2),
        .sel_err(serr2), .out_data(od2), .out_chan(oc2), .out_valid(ov2), .out_ready(or2));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tot_cnt++;
        if (a === e) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask

    // Reference model: arbitration from the rules, expected words pushed on each transfer.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                bit ld, g;
                int gi, n;
                n  = d ? q1.size() : q0.size();
                ld = (n == 0) || ordy[d];
                g  = 0;
                gi = 0;
                if (d == 0) begin
                    if (sel[0] < 4 && iv[0][sel[0]]) begin
                        g  = 1;
                        gi = int'(sel[0]);
                    end
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        if (!g && iv[1][(mptr + k) % 4]) begin
                            g  = 1;
                            gi = (mptr + k) % 4;
                        end
                    end
                end
                chk(d ? "in_ready1" : "in_ready0", 32'(ir[d]), (ld && g) ? 32'(1) << gi : 32'd0);
                chk(d ? "sel_err1" : "sel_err0", 32'(serr[d]), (d == 0 && sel[0] >= 4) ? 32'd1 : 32'd0);
                took[d] = 4'b0;
                if (ld && g) begin
                    if (d == 0) q0.push_back({bus[0][gi*8 +: 8], 4'(gi)});
                    else begin
                        q1.push_back({bus[1][gi*8 +: 8], 4'(gi)});
                        mptr = (gi + 1) % 4;
                    end
                    took[d][gi] = 1'b1;
                end
            end
        end
    end

    // Monitor: compare whatever the DUT presents against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                logic [11:0] e;
                int n;
                n = d ? q1.size() : q0.size();
                chk(d ? "out_valid1" : "out_valid0", 32'(ov[d]), 32'(n != 0));
                if (ov[d] && n > 0) begin
                    e = d ? q1[0] : q0[0];
                    chk(d ? "out_data1" : "out_data0", 32'(od[d]), 32'(e[11:4]));
                    chk(d ? "out_chan1" : "out_chan0", 32'(oc[d]), 32'(e[3:0]));
                    if (ordy[d]) begin
                        if (d == 0) void'(q0.pop_front());
                        else void'(q1.pop_front());
                    end
                end
            end
        end
    end

    // Random producers: hold a word until it transfers, then drop or offer a new one.
    always @(posedge clk) begin
        #1;
        if (rand_on) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 4; c++) begin
                    if (took[d][c] || !iv[d][c]) begin
                        if ($urandom_range(0, 1) == 1) begin
                            iv[d][c] = 1'b1;
                            bus[d][c*8 +: 8] = 8'($urandom);
                        end else iv[d][c] = 1'b0;
                    end
                end
                ordy[d] = $urandom_range(0, 3) != 0;
            end
            sel[0] = 4'($urandom_range(0, 5));
        end
    end

    initial begin
        logic [3:0] fair[8];
        fair = '{4'd0, 4'd1, 4'd3, 4'd0, 4'd1, 4'd3, 4'd0, 4'd1};
        for (int d = 0; d < 2; d++) begin
            bus[d] = '0; iv[d] = '0; sel[d] = '0; ordy[d] = 1'b0; took[d] = '0;
        end
        bus2 = '0; iv2 = '0; sel2 = '0; or2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid1", 32'(ov[1]), 0);
        chk("rst_out_data1", 32'(od[1]), 0);
        chk("rst_out_chan1", 32'(oc[1]), 0);
        chk("rst_out_valid0", 32'(ov[0]), 0);
        rst = 0;
        // select mode picks channel 2
        bus[0] = 32'hDDCCBBAA; iv[0] = 4'b1111; sel[0] = 4'd2; ordy[0] = 1'b1;
        #1;
        chk("sel_in_ready", 32'(ir[0]), 32'h4);
        @(posedge clk); #1;
        chk("sel_out_data", 32'(od[0]), 32'hCC);
        chk("sel_out_chan", 32'(oc[0]), 2);
        chk("sel_out_valid", 32'(ov[0]), 1);
        iv[0] = 4'b0;
        // out-of-range select on three channels
        bus2 = 24'hCCBBAA; iv2 = 3'b111; sel2 = 4'd3; or2 = 1'b1;
        #1;
        chk("oor_sel_err", 32'(serr2), 1);
        chk("oor_in_ready", 32'(ir2), 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("oor_out_valid", 32'(ov2), 0);
        end
        // round-robin fairness
        bus[1] = 32'hDDCCBBAA; iv[1] = 4'b1011; ordy[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("rr_out_chan", 32'(oc[1]), 32'(fair[i]));
            chk("rr_out_valid", 32'(ov[1]), 1);
        end
        // backpressure after channel 1 loads
        ordy[1] = 1'b0;
        #1;
        chk("bp_in_ready", 32'(ir[1]), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_out_chan", 32'(oc[1]), 1);
            chk("bp_out_data", 32'(od[1]), 32'hBB);
            chk("bp_in_ready", 32'(ir[1]), 0);
        end
        ordy[1] = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(ir[1]), 32'h8);
        @(posedge clk); #1;
        chk("bp_next_chan", 32'(oc[1]), 3);
        chk("bp_next_data", 32'(od[1]), 32'hDD);
        // pointer wrap
        iv[1] = 4'b1000;
        @(posedge clk); #1;
        chk("wrap_chan3", 32'(oc[1]), 3);
        iv[1] = 4'b0001;
        #1;
        chk("wrap_in_ready", 32'(ir[1]), 32'h1);
        @(posedge clk); #1;
        chk("wrap_chan0", 32'(oc[1]), 0);
        iv[1] = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        rand_on = 1;
        repeat (1500) @(posedge clk);
        #3;
        rand_on = 0;
        // asynchronous reset with a word held
        ordy[1] = 1'b0; iv[1] = 4'hF;
        @(posedge clk); #1;
        chk("pre_rst_valid", 32'(ov[1]), 1);
        rst = 1;
        #1;
        chk("arst_out_valid", 32'(ov[1]), 0);
        chk("arst_out_data", 32'(od[1]), 0);
        chk("arst_out_chan", 32'(oc[1]), 0);
        chk("arst_in_ready", 32'(ir[1]), 0);
        q0.delete(); q1.delete(); mptr = 0;
        iv[0] = 4'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0; ordy[1] = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_chan", 32'(oc[1]), 0);
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
